pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers. It carries a DATA_W payload plus a CTRL_W control bundle between two pipeline stages.
- Adds a valid/ready handshake, a one-entry skid buffer so back-pressure never forms a combinational ready path, and a synchronous flush that turns contents into bubbles.
- Adds saturating stall/bubble/flush performance counters.
- Drop-in for any stage boundary: ID/EX, EX/MEM, MEM/WB.

---
 rtl/pipe_stage_skid.sv | 90 +++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush to bubbles and saturating stall/bubble/flush counters.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              accept;
  logic              fire;

  // in_ready comes straight off a flop, so back-pressure never ripples upstream.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload registers are reset too, because downstream may decode ctrl without valid.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= BUBBLE_CTRL;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (skid_valid) begin
      if (fire) begin
        out_data   <= skid_data;
        out_ctrl   <= skid_ctrl;
        skid_valid <= 1'b0;
        skid_data  <= '0;
        skid_ctrl  <= '0;
      end
    end else if (accept) begin
      if (out_valid && !fire) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
      end else begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_ctrl  <= in_ctrl;
      end
    end else if (fire) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= BUBBLE_CTRL;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt, out_valid && !out_ready);
      bubble_cnt <= sat_inc(bubble_cnt, !out_valid);
      flush_cnt  <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue scoreboard checks every delivered item
// in order, while the stimulus process checks state, occupancy and counters at fixed points.
module tb_pipe_stage_skid;

  localparam logic [15:0] BUB = 16'h0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_out_data;
  logic [15:0] sat_out_ctrl;
  logic [1:0]  sat_occupancy;
  logic [3:0]  sat_stall_cnt, sat_bubble_cnt, sat_flush_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  logic [47:0] exp_q[$];

  always #5 clock = ~clock;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_ctrl(sat_out_ctrl), .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt),
    .bubble_cnt(sat_bubble_cnt), .flush_cnt(sat_flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard bookkeeping at the edge, then move #1 past it to drive and check.
  task automatic step();
    @(posedge clock);
    if (!reset || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back({in_data, in_ctrl});
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = d[15:0] ^ 16'h5A00;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 32'h0);
    check({tag, "_ctrl"}, out_ctrl, BUB);
    check({tag, "_occ"}, occupancy, 2'd0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Monitor: pops one expected item per delivery, checks bubbles otherwise.
  always @(negedge clock) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL out_unexpected: got data 0x%0h, expected no item", out_data);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          check("out_data", out_data, e[47:16]);
          check("out_ctrl", out_ctrl, e[15:0]);
        end
      end else if (!out_valid) begin
        check("bubble_data", out_data, 32'h0);
        check("bubble_ctrl", out_ctrl, BUB);
      end
    end
  end

  initial begin
    // Reset held two cycles with a live upstream item.
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    step();
    check_bubble("rst");
    check("rst_stall", stall_cnt, 16'd0);
    check("rst_bubble", bubble_cnt, 16'd0);
    check("rst_flush", flush_cnt, 16'd0);

    // Streaming 1..4 with downstream always ready.
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_data", out_data, 32'(i));
      check("stream_occ", occupancy, 2'd1);
      check("stream_stall", stall_cnt, 16'd0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_bubble("drain");
    check("drain_bubble_cnt", bubble_cnt, 16'd1);

    // Back-pressure: A then B fill main and skid.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    check("bp_occ1", occupancy, 2'd1);
    check("bp_in_ready1", in_ready, 1'b1);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    step();
    check("bp_occ2", occupancy, 2'd2);
    check("bp_in_ready0", in_ready, 1'b0);
    check("bp_hold_data", out_data, 32'h11);
    check("bp_stall1", stall_cnt, 16'd1);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    step();
    check("bp_hold_data2", out_data, 32'h11);
    check("bp_stall2", stall_cnt, 16'd2);
    check("bp_occ2b", occupancy, 2'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("bp_skid_to_main", out_data, 32'h22);
    check("bp_occ_after_fire", occupancy, 2'd1);
    check("bp_in_ready_after_fire", in_ready, 1'b1);
    step();
    check("bp_empty_occ", occupancy, 2'd0);
    check("bp_stall_final", stall_cnt, 16'd2);
    check("bp_bubble", bubble_cnt, 16'd2);

    // Flush while in SKID with upstream still valid.
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hA2, 1'b0, 1'b0);
    step();
    check("fl_occ_skid", occupancy, 2'd2);
    drive(1'b1, 32'hA3, 1'b0, 1'b1);
    step();
    check_bubble("fl_skid");
    check("fl_cnt1", flush_cnt, 16'd1);
    // Flush with an accepted item in the same cycle: handshake completes, item dropped.
    drive(1'b1, 32'hA4, 1'b1, 1'b1);
    step();
    check_bubble("fl_accept");
    check("fl_cnt2", flush_cnt, 16'd2);
    // Flush coinciding with a fire: B1 is delivered, B2 is dropped.
    drive(1'b1, 32'hB1, 1'b1, 1'b0);
    step();
    check("fl_full_data", out_data, 32'hB1);
    drive(1'b1, 32'hB2, 1'b1, 1'b1);
    step();
    check_bubble("fl_fire");
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("fl_cnt3", flush_cnt, 16'd3);
    check("fl_stall", stall_cnt, 16'd4);
    check("fl_bubble", bubble_cnt, 16'd6);
    check("fl_pending", exp_q.size(), 0);

    // Reset together with flush in the middle of SKID.
    drive(1'b1, 32'hC1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC2, 1'b0, 1'b0);
    step();
    check("mr_occ_skid", occupancy, 2'd2);
    reset = 1'b0;
    drive(1'b1, 32'hC3, 1'b1, 1'b1);
    step();
    check_bubble("mr");
    check("mr_stall", stall_cnt, 16'd0);
    check("mr_bubble", bubble_cnt, 16'd0);
    check("mr_flush", flush_cnt, 16'd0);

    // Saturation: twenty idle cycles against a 4-bit counter.
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) check("sat_bubble14", sat_bubble_cnt, 4'd14);
      if (i == 15) check("sat_bubble15", sat_bubble_cnt, 4'd15);
    end
    check("sat_bubble_hold", sat_bubble_cnt, 4'd15);
    check("sat_stall", sat_stall_cnt, 4'd0);
    check("wide_bubble", bubble_cnt, 16'd20);

    @(negedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
